// File: rtl/pla_pkg.sv
// Row layout, legacy program and term-match helper shared by the PLA evaluator.
// Term row = {en, value, care}; output row = {inv, or_mask}.
package pla_pkg;

  localparam int MAX_IN       = 32;
  localparam int LEG_N_IN     = 7;
  localparam int LEG_N_OUT    = 3;
  localparam int LEG_N_TERMS  = 3;

  localparam logic [6:0] LEG_CARE_T0 = 7'b0010011;  // a, b, e
  localparam logic [6:0] LEG_CARE_T1 = 7'b0011010;  // b, d, e
  localparam logic [6:0] LEG_CARE_T2 = 7'b1111100;  // c, d, e, f, g

  function automatic int calc_cfg_w(input int n_in, input int n_term);
    return (2 * n_in + 1 > n_term + 1) ? 2 * n_in + 1 : n_term + 1;
  endfunction

  function automatic int row_count(input int n_term, input int n_out);
    return n_term + n_out;
  endfunction

  function automatic int term_val_lsb(input int n_in);
    return n_in;
  endfunction

  function automatic int term_en_bit(input int n_in);
    return 2 * n_in;
  endfunction

  function automatic int out_inv_bit(input int n_term);
    return n_term;
  endfunction

  function automatic logic term_match(input logic [MAX_IN-1:0] data,
                                      input logic [MAX_IN-1:0] care,
                                      input logic [MAX_IN-1:0] value,
                                      input logic              en);
    return en & ~|(care & (data ^ value));
  endfunction

  function automatic logic legacy_honoured(input int n_in, input int n_out, input int n_term);
    return (n_in == LEG_N_IN) && (n_out == LEG_N_OUT) && (n_term >= LEG_N_TERMS);
  endfunction

  // Legacy terms require every cared bit to be 1, so value equals care.
  function automatic logic [6:0] legacy_care(input int t);
    case (t)
      0:       return LEG_CARE_T0;
      1:       return LEG_CARE_T1;
      2:       return LEG_CARE_T2;
      default: return '0;
    endcase
  endfunction

  function automatic logic legacy_en(input int t);
    return t < LEG_N_TERMS;
  endfunction

  function automatic logic legacy_inv(input int o);
    return o != 0;
  endfunction

endpackage

// File: rtl/pla_eval_if.sv
// Input stream, result stream and config-write bundle of the PLA evaluator.
// The master side drives vectors and config; the slave side is the evaluator.
interface pla_eval_if #(
  parameter int N_IN   = 7,
  parameter int N_OUT  = 3,
  parameter int CFG_W  = 15,
  parameter int ADDR_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [N_IN-1:0]   in_data;
  logic              out_valid;
  logic              out_ready;
  logic [N_OUT-1:0]  out_data;
  logic              cfg_we;
  logic              cfg_ready;
  logic [ADDR_W-1:0] cfg_addr;
  logic [CFG_W-1:0]  cfg_data;
  logic              cfg_err;

  modport master (
    output in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_data, cfg_ready, cfg_err
  );

  modport slave (
    input  in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
    output in_ready, out_valid, out_data, cfg_ready, cfg_err
  );
endinterface

// File: rtl/pla_term.sv
// One product term: combinational match of the input vector against care/value/en.
// Zero latency, no flow control.
module pla_term
  import pla_pkg::*;
#(
  parameter int N_IN = 7
) (
  input  logic [N_IN-1:0] i_data,
  input  logic [N_IN-1:0] i_care,
  input  logic [N_IN-1:0] i_value,
  input  logic            i_en,
  output logic            o_term
);

  assign o_term = term_match(MAX_IN'(i_data), MAX_IN'(i_care), MAX_IN'(i_value), i_en);

endmodule

// File: rtl/pla_eval.sv
// Programmable sum-of-products evaluator: terms registered in stage 1, OR/invert in stage 2.
// Two-cycle latency, one result per cycle; stalls on out_ready low; config only when empty.
module pla_eval
  import pla_pkg::*;
#(
  parameter int N_IN         = 7,
  parameter int N_TERM       = 8,
  parameter int N_OUT        = 3,
  parameter int LEGACY_RESET = 1,
  parameter int CFG_W        = calc_cfg_w(N_IN, N_TERM)
) (
  input logic       clk,
  input logic       rst,
  pla_eval_if.slave io_bus
);

  localparam int ADDR_W  = $clog2(N_TERM + N_OUT);
  localparam int N_ROWS  = row_count(N_TERM, N_OUT);
  localparam int VAL_LSB = term_val_lsb(N_IN);
  localparam int EN_BIT  = term_en_bit(N_IN);
  localparam int INV_BIT = out_inv_bit(N_TERM);
  localparam bit LEG     = (LEGACY_RESET != 0) && legacy_honoured(N_IN, N_OUT, N_TERM);
  localparam logic [ADDR_W:0] ROWS_L = (ADDR_W + 1)'(N_ROWS);

  logic [N_IN-1:0]   r_care  [N_TERM];
  logic [N_IN-1:0]   r_value [N_TERM];
  logic [N_TERM-1:0] r_en;
  logic [N_TERM-1:0] r_mask  [N_OUT];
  logic [N_OUT-1:0]  r_inv;

  logic              r_s1_valid;
  logic [N_TERM-1:0] r_s1_terms;
  logic              r_out_valid;
  logic [N_OUT-1:0]  r_out_data;
  logic              r_cfg_err;

  logic [CFG_W-1:0]  w_cfg_data;
  logic [N_TERM-1:0] w_terms;
  logic [N_OUT-1:0]  w_outs;
  logic              w_s2_adv;
  logic              w_s1_adv;
  logic              w_cfg_ready;
  logic              w_cfg_fire;
  logic              w_addr_ok;
  logic              w_in_ready;
  logic              w_in_fire;

  assign w_cfg_data  = io_bus.cfg_data;
  assign w_s2_adv    = ~r_out_valid | io_bus.out_ready;
  assign w_s1_adv    = ~r_s1_valid | w_s2_adv;
  assign w_cfg_ready = ~r_s1_valid & ~r_out_valid;
  assign w_cfg_fire  = io_bus.cfg_we & w_cfg_ready;
  assign w_addr_ok   = {1'b0, io_bus.cfg_addr} < ROWS_L;
  // A config write takes the cycle; the input waits one cycle and sees the new program.
  assign w_in_ready  = w_s1_adv & ~w_cfg_fire;
  assign w_in_fire   = io_bus.in_valid & w_in_ready;

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.cfg_ready = w_cfg_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_data  = r_out_data;
  assign io_bus.cfg_err   = r_cfg_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < N_TERM; t++) begin
        r_care[t]  <= LEG ? N_IN'(legacy_care(t)) : '0;
        r_value[t] <= LEG ? N_IN'(legacy_care(t)) : '0;
        r_en[t]    <= LEG && legacy_en(t);
      end
      for (int o = 0; o < N_OUT; o++) begin
        r_mask[o] <= LEG ? (N_TERM'(1) << o) : '0;
        r_inv[o]  <= LEG && legacy_inv(o);
      end
    end else if (w_cfg_fire && w_addr_ok) begin
      for (int t = 0; t < N_TERM; t++) begin
        if (io_bus.cfg_addr == ADDR_W'(t)) begin
          r_care[t]  <= w_cfg_data[N_IN-1:0];
          r_value[t] <= w_cfg_data[VAL_LSB +: N_IN];
          r_en[t]    <= w_cfg_data[EN_BIT];
        end
      end
      for (int o = 0; o < N_OUT; o++) begin
        if (io_bus.cfg_addr == ADDR_W'(N_TERM + o)) begin
          r_mask[o] <= w_cfg_data[N_TERM-1:0];
          r_inv[o]  <= w_cfg_data[INV_BIT];
        end
      end
    end
  end

  for (genvar t = 0; t < N_TERM; t++) begin : g_term
    pla_term #(.N_IN(N_IN)) u_term (
      .i_data  (io_bus.in_data),
      .i_care  (r_care[t]),
      .i_value (r_value[t]),
      .i_en    (r_en[t]),
      .o_term  (w_terms[t])
    );
  end

  always_comb begin
    w_outs = '0;
    for (int o = 0; o < N_OUT; o++) begin
      w_outs[o] = r_inv[o] ^ (|(r_s1_terms & r_mask[o]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_terms  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_cfg_err   <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= w_in_fire;
        if (w_in_fire) r_s1_terms <= w_terms;
      end
      if (w_s2_adv) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) r_out_data <= w_outs;
      end
      r_cfg_err <= w_cfg_fire & ~w_addr_ok;
    end
  end

endmodule

// File: tb/tb_pla_eval.sv
// Directed and randomized checks of pla_eval against a row-table model of the program.
module tb_pla_eval;

  localparam int N_IN   = 7;
  localparam int N_TERM = 8;
  localparam int N_OUT  = 3;
  localparam int CFG_W  = 15;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pla_eval_if #(.N_IN(N_IN), .N_OUT(N_OUT), .CFG_W(CFG_W), .ADDR_W(ADDR_W)) bus ();

  pla_eval #(
    .N_IN(N_IN), .N_TERM(N_TERM), .N_OUT(N_OUT), .LEGACY_RESET(1), .CFG_W(CFG_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [6:0] m_care [N_TERM];
  logic [6:0] m_val  [N_TERM];
  logic       m_en   [N_TERM];
  logic [7:0] m_mask [N_OUT];
  logic       m_inv  [N_OUT];

  logic [2:0] exp_q[$];
  logic       exp_err;
  logic       held_vld;
  logic [2:0] held_dat;
  logic       last_in_fire;
  logic       last_cfg_fire;
  int         n_out_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int t = 0; t < N_TERM; t++) begin
      m_care[t] = '0; m_val[t] = '0; m_en[t] = 1'b0;
    end
    m_care[0] = 7'b0010011; m_val[0] = 7'b0010011; m_en[0] = 1'b1;
    m_care[1] = 7'b0011010; m_val[1] = 7'b0011010; m_en[1] = 1'b1;
    m_care[2] = 7'b1111100; m_val[2] = 7'b1111100; m_en[2] = 1'b1;
    m_mask[0] = 8'b0000_0001; m_inv[0] = 1'b0;
    m_mask[1] = 8'b0000_0010; m_inv[1] = 1'b1;
    m_mask[2] = 8'b0000_0100; m_inv[2] = 1'b1;
  endfunction

  function automatic void model_write(input logic [3:0] a, input logic [14:0] d);
    if (a < 4'd8) begin
      m_en[a] = d[14]; m_val[a] = d[13:7]; m_care[a] = d[6:0];
    end else if (a < 4'd11) begin
      m_mask[a - 4'd8] = d[7:0]; m_inv[a - 4'd8] = d[8];
    end
  endfunction

  function automatic logic [2:0] model(input logic [6:0] d);
    logic [2:0] r;
    r = '0;
    for (int o = 0; o < N_OUT; o++) begin
      bit hit = 0;
      for (int t = 0; t < N_TERM; t++) begin
        if (m_en[t] && m_mask[o][t]) begin
          bit ok = 1;
          for (int i = 0; i < N_IN; i++)
            if (m_care[t][i] && (d[i] != m_val[t][i])) ok = 0;
          if (ok) hit = 1;
        end
      end
      r[o] = hit ^ m_inv[o];
    end
    return r;
  endfunction

  // Observe at the falling edge, then step past the next rising edge.
  task automatic tick();
    @(negedge clk);
    last_in_fire  = 1'b0;
    last_cfg_fire = 1'b0;
    if (rst) begin
      model_reset();
      exp_q.delete();
      exp_err  = 1'b0;
      held_vld = 1'b0;
    end else begin
      chk("cfg_err", bus.cfg_err, exp_err);
      if (held_vld) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_hold", bus.out_data, held_dat);
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_out", bus.out_valid, 0);
        else chk("out_data", bus.out_data, exp_q[0]);
      end
      exp_err  = 1'b0;
      held_vld = bus.out_valid && !bus.out_ready;
      held_dat = bus.out_data;
      if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        n_out_seen++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.in_data));
        last_in_fire = 1'b1;
      end
      if (bus.cfg_we && bus.cfg_ready) begin
        exp_err = ({1'b0, bus.cfg_addr} >= 5'd11);
        model_write(bus.cfg_addr, bus.cfg_data);
        last_cfg_fire = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [6:0] d, input logic [2:0] want, input string tag);
    bus.in_valid = 1'b1; bus.in_data = d; bus.out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    chk({tag, "_lat_s1"}, bus.out_valid, 0);
    tick();
    chk({tag, "_valid"}, bus.out_valid, 1);
    chk({tag, "_data"}, bus.out_data, want);
    tick();
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [14:0] d, input string tag);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_data = d;
    #1;
    chk({tag, "_cfg_ready"}, bus.cfg_ready, 1);
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic drain(input string tag);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int c = 0; c < 50 && !(bus.cfg_ready && exp_q.size() == 0); c++) tick();
    chk({tag, "_drained"}, bus.cfg_ready, 1);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic stream(input int n, input logic [3:0] pat, input string tag);
    int sent = 0;
    int seen0 = n_out_seen;
    bus.in_valid = 1'b1; bus.in_data = 7'($urandom);
    for (int c = 0; c < 400 && sent < n; c++) begin
      bus.out_ready = pat[c % 4];
      tick();
      if (last_in_fire) begin
        sent++;
        bus.in_data = 7'($urandom);
      end
    end
    bus.in_valid = 1'b0;
    drain(tag);
    chk({tag, "_count"}, n_out_seen - seen0, n);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    model_reset();
    exp_err = 1'b0; held_vld = 1'b0; held_dat = '0; n_out_seen = 0;
    last_in_fire = 1'b0; last_cfg_fire = 1'b0;
    #1;
    tick();
    tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_cfg_err", bus.cfg_err, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_cfg_ready", bus.cfg_ready, 1);

    // Legacy program: {z,y,x}
    send_one(7'b0010011, 3'b111, "leg_abe");
    send_one(7'b1111111, 3'b001, "leg_ones");
    stream(20, 4'b1111, "leg_rand");

    // Term 3 matches a==0, routed alone to x
    cfg_write(4'd3, {1'b1, 7'b0000000, 7'b0000001}, "t3");
    cfg_write(4'd8, {6'b0, 1'b0, 8'b0000_1000}, "x_t3");
    send_one(7'b0000000, 3'b111, "t3_zero");
    send_one(7'b0000001, 3'b110, "t3_one");

    // Backpressure with out_ready 1,0,0,1
    stream(10, 4'b1001, "bp");

    // Config and input together on an empty pipe
    bus.cfg_we = 1'b1; bus.cfg_addr = 4'd8; bus.cfg_data = 15'h0101;
    bus.in_valid = 1'b1; bus.in_data = 7'b0010011; bus.out_ready = 1'b1;
    #1;
    chk("sim_cfg_ready", bus.cfg_ready, 1);
    chk("sim_in_ready", bus.in_ready, 0);
    tick();
    chk("sim_cfg_taken", last_cfg_fire, 1);
    chk("sim_in_held", last_in_fire, 0);
    bus.cfg_we = 1'b0;
    #1;
    chk("sim_in_ready_next", bus.in_ready, 1);
    tick();
    chk("sim_in_taken", last_in_fire, 1);
    bus.in_valid = 1'b0;
    tick();
    chk("sim_valid", bus.out_valid, 1);
    chk("sim_data", bus.out_data, 3'b110);
    tick();

    // Out-of-range row
    bus.cfg_we = 1'b1; bus.cfg_addr = 4'd11; bus.cfg_data = '1;
    #1;
    chk("bad_cfg_ready", bus.cfg_ready, 1);
    tick();
    bus.cfg_we = 1'b0;
    chk("bad_err_pulse", bus.cfg_err, 1);
    tick();
    chk("bad_err_once", bus.cfg_err, 0);
    send_one(7'b0010011, 3'b110, "bad_unchanged");

    // Config held off while the pipe is busy
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = 7'b0000000;
    tick();
    bus.in_valid = 1'b0;
    bus.cfg_we = 1'b1; bus.cfg_addr = 4'd8; bus.cfg_data = 15'h0008;
    #1;
    chk("busy_cfg_ready", bus.cfg_ready, 0);
    tick();
    tick();
    chk("busy_cfg_ready_hold", bus.cfg_ready, 0);
    chk("busy_no_accept", last_cfg_fire, 0);
    bus.out_ready = 1'b1;
    last_cfg_fire = 1'b0;
    for (int c = 0; c < 20 && !last_cfg_fire; c++) tick();
    chk("busy_cfg_accept", last_cfg_fire, 1);
    bus.cfg_we = 1'b0;
    send_one(7'b0000001, 3'b110, "busy_new_prog");

    // Reset with both stages full restores the legacy program
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = 7'($urandom);
    tick();
    bus.in_data = 7'($urandom);
    tick();
    #1;
    chk("full_in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst_mid_out_valid", bus.out_valid, 0);
    chk("rst_mid_cfg_ready", bus.cfg_ready, 1);
    rst = 1'b0;
    send_one(7'b0010011, 3'b111, "rst_legacy");
    stream(12, 4'b1001, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
